// File: rtl/cdma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cdma_mem_responder
// Purpose  : Memory-backed responder for the cDMA slave user interface.
//            Accepts burst write and read requests, stores write beats in an
//            internal single-port word memory, and returns read beats through
//            a 2-entry skid buffer that honours rready backpressure.
// Ports    : ui_clk / ui_rstn        - clock, async active-low reset
//            i_cdma_waddr/_vld/wsize - write request (byte addr, beat count)
//            o_cdma_wbusy            - write burst in progress
//            i_cdma_wdata/wvalid     - write beat, o_cdma_wready handshake
//            i_cdma_raddr/_vld/rsize - read request (byte addr, beat count)
//            o_cdma_rbusy            - read burst in progress
//            o_cdma_rdata/rvalid     - read beat, i_cdma_rready handshake
//            o_err                   - sticky: wvalid seen while not write-busy
// Revision : 1.0 - initial release
// ============================================================================
module cdma_mem_responder #(
  parameter int MEM_WORDS  = 8192,
  parameter int WREADY_GAP = 0
) (
  input  logic        ui_clk,
  input  logic        ui_rstn,
  input  logic [31:0] i_cdma_waddr,
  input  logic        i_cdma_waddr_vld,
  input  logic [15:0] i_cdma_wsize,
  output logic        o_cdma_wbusy,
  input  logic [31:0] i_cdma_wdata,
  input  logic        i_cdma_wvalid,
  output logic        o_cdma_wready,
  input  logic [31:0] i_cdma_raddr,
  input  logic        i_cdma_raddr_vld,
  input  logic [15:0] i_cdma_rsize,
  output logic        o_cdma_rbusy,
  output logic [31:0] o_cdma_rdata,
  output logic        o_cdma_rvalid,
  input  logic        i_cdma_rready,
  output logic        o_err
);

  localparam int          AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [15:0] GAP_LAST = 16'(WREADY_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;     // write: beats left; read: memory reads left to issue
  logic [15:0]   dlv_q, dlv_d;     // read beats left to deliver
  logic [15:0]   gap_q, gap_d;     // accepted write beats since the last wready gap
  logic          warm_q, warm_d, rarm_q, rarm_d;
  logic          wbusy_q, wbusy_d, rbusy_q, rbusy_d;
  logic          wready_q, wready_d, err_q, err_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    occ_q, occ_d;     // skid buffer occupancy
  logic [31:0]   b0_q, b0_d, b1_q, b1_d;
  logic [31:0]   ram_q;
  logic [31:0]   mem [MEM_WORDS];

  logic w_wr_accept, w_rd_accept, w_wbeat, w_rpop, w_rissue;
  logic w_unused;

  assign w_unused = ^{i_cdma_waddr[31:AW+2], i_cdma_waddr[1:0],
                      i_cdma_raddr[31:AW+2], i_cdma_raddr[1:0]};

  assign w_wr_accept = (state_q == S_IDLE) && i_cdma_waddr_vld && warm_q;
  // Write wins a tie; the losing read simply stays pending.
  assign w_rd_accept = (state_q == S_IDLE) && i_cdma_raddr_vld && rarm_q && !w_wr_accept;
  assign w_wbeat     = (state_q == S_WR) && i_cdma_wvalid && wready_q;
  assign w_rpop      = (occ_q != 2'd0) && i_cdma_rready;
  // Issue only if the buffer can absorb the result, counting the read already
  // in flight; a pop in this cycle frees a slot, keeping one beat per cycle.
  assign w_rissue    = (state_q == S_RD) && (cnt_q != 16'd0) &&
                       (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_rpop}));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    dlv_d      = dlv_q;
    gap_d      = gap_q;
    warm_d     = warm_q | ~i_cdma_waddr_vld;
    rarm_d     = rarm_q | ~i_cdma_raddr_vld;
    wbusy_d    = wbusy_q;
    rbusy_d    = rbusy_q;
    wready_d   = wready_q;
    err_d      = err_q | (i_cdma_wvalid & ~wbusy_q);
    inflight_d = w_rissue;
    b0_d       = b0_q;
    b1_d       = b1_q;
    occ_d      = occ_q;

    // Skid buffer: pop the head first, then append the returning RAM word.
    if (w_rpop) begin
      b0_d  = b1_q;
      occ_d = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) b0_d = ram_q;
      else               b1_d = ram_q;
      occ_d = occ_d + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_wr_accept) begin
          state_d  = S_WR;
          ptr_d    = i_cdma_waddr[AW+1:2];
          cnt_d    = i_cdma_wsize;
          gap_d    = 16'd0;
          warm_d   = 1'b0;
          wbusy_d  = 1'b1;
          wready_d = (i_cdma_wsize != 16'd0);
        end else if (w_rd_accept) begin
          state_d = S_RD;
          ptr_d   = i_cdma_raddr[AW+1:2];
          cnt_d   = i_cdma_rsize;
          dlv_d   = i_cdma_rsize;
          rarm_d  = 1'b0;
          rbusy_d = 1'b1;
        end
      end
      S_WR: begin
        if (w_wbeat) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            wready_d = 1'b0;
            state_d  = S_DONE;
          end else if ((WREADY_GAP != 0) && (gap_q == GAP_LAST)) begin
            wready_d = 1'b0;
            gap_d    = 16'd0;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end else if (cnt_q == 16'd0) begin
          state_d = S_DONE;           // zero-length burst
        end else begin
          wready_d = 1'b1;            // reopen after a one-cycle gap
        end
      end
      S_RD: begin
        if (w_rissue) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q - 16'd1;
        end
        if (dlv_q == 16'd0) begin
          state_d = S_DONE;
        end else if (w_rpop) begin
          dlv_d = dlv_q - 16'd1;
          if (dlv_q == 16'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wbusy_d  = 1'b0;
        rbusy_d  = 1'b0;
        wready_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= 16'd0;
      dlv_q      <= 16'd0;
      gap_q      <= 16'd0;
      warm_q     <= 1'b1;
      rarm_q     <= 1'b1;
      wbusy_q    <= 1'b0;
      rbusy_q    <= 1'b0;
      wready_q   <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      b0_q       <= 32'd0;
      b1_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      dlv_q      <= dlv_d;
      gap_q      <= gap_d;
      warm_q     <= warm_d;
      rarm_q     <= rarm_d;
      wbusy_q    <= wbusy_d;
      rbusy_q    <= rbusy_d;
      wready_q   <= wready_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end

  // Single-port memory: writes happen only in WR, reads only in RD.
  always_ff @(posedge ui_clk) begin
    if (w_wbeat)  mem[ptr_q] <= i_cdma_wdata;
    if (w_rissue) ram_q      <= mem[ptr_q];
  end

  assign o_cdma_wbusy  = wbusy_q;
  assign o_cdma_wready = wready_q;
  assign o_cdma_rbusy  = rbusy_q;
  assign o_cdma_rdata  = b0_q;
  assign o_cdma_rvalid = (occ_q != 2'd0);
  assign o_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cdma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdma_mem_responder
// Purpose  : Directed self-checking bench for cdma_mem_responder. A default
//            instance (8192 words, no wready gap) and a small instance
//            (8 words, wready gap every 3 beats) share one stimulus set;
//            `sel` routes handshakes to one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdma_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [15:0] wsize = '0, rsize = '0;
  logic        waddr_vld = 1'b0, wvalid = 1'b0, raddr_vld = 1'b0, rready = 1'b0;

  logic        b_wbusy, b_wready, b_rbusy, b_rvalid, b_err;
  logic        s_wbusy, s_wready, s_rbusy, s_rvalid, s_err;
  logic [31:0] b_rdata, s_rdata;
  logic        b_wvld, b_wv, b_rvld, b_rr, s_wvld, s_wv, s_rvld, s_rr;
  logic        wbusy, wready, rbusy, rvalid, err;
  logic [31:0] rdata;

  int vec = 0, miscmp = 0, tmo = 0, rb_during_w = 0;

  always #5 clk = ~clk;

  assign b_wvld = waddr_vld & ~sel;  assign s_wvld = waddr_vld & sel;
  assign b_wv   = wvalid & ~sel;     assign s_wv   = wvalid & sel;
  assign b_rvld = raddr_vld & ~sel;  assign s_rvld = raddr_vld & sel;
  assign b_rr   = rready & ~sel;     assign s_rr   = rready & sel;
  assign wbusy  = sel ? s_wbusy  : b_wbusy;
  assign wready = sel ? s_wready : b_wready;
  assign rbusy  = sel ? s_rbusy  : b_rbusy;
  assign rvalid = sel ? s_rvalid : b_rvalid;
  assign rdata  = sel ? s_rdata  : b_rdata;
  assign err    = sel ? s_err    : b_err;

  cdma_mem_responder #(.MEM_WORDS(8192), .WREADY_GAP(0)) u_dut (
    .ui_clk(clk), .ui_rstn(rst_n),
    .i_cdma_waddr(waddr), .i_cdma_waddr_vld(b_wvld), .i_cdma_wsize(wsize),
    .o_cdma_wbusy(b_wbusy), .i_cdma_wdata(wdata), .i_cdma_wvalid(b_wv),
    .o_cdma_wready(b_wready),
    .i_cdma_raddr(raddr), .i_cdma_raddr_vld(b_rvld), .i_cdma_rsize(rsize),
    .o_cdma_rbusy(b_rbusy), .o_cdma_rdata(b_rdata), .o_cdma_rvalid(b_rvalid),
    .i_cdma_rready(b_rr), .o_err(b_err)
  );

  cdma_mem_responder #(.MEM_WORDS(8), .WREADY_GAP(3)) u_small (
    .ui_clk(clk), .ui_rstn(rst_n),
    .i_cdma_waddr(waddr), .i_cdma_waddr_vld(s_wvld), .i_cdma_wsize(wsize),
    .o_cdma_wbusy(s_wbusy), .i_cdma_wdata(wdata), .i_cdma_wvalid(s_wv),
    .o_cdma_wready(s_wready),
    .i_cdma_raddr(raddr), .i_cdma_raddr_vld(s_rvld), .i_cdma_rsize(rsize),
    .o_cdma_rbusy(s_rbusy), .o_cdma_rdata(s_rdata), .o_cdma_rvalid(s_rvalid),
    .i_cdma_rready(s_rr), .o_err(s_err)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wait_wbusy();
    int t = 0;
    while (!wbusy && t < 100) begin @(negedge clk); t++; end
    if (!wbusy) tmo++;
  endtask

  task automatic wait_rbusy();
    int t = 0;
    while (!rbusy && t < 100) begin @(negedge clk); t++; end
    if (!rbusy) tmo++;
  endtask

  task automatic wr_start(input logic [31:0] addr, input logic [15:0] size);
    @(negedge clk);
    waddr = addr; wsize = size; waddr_vld = 1'b1;
    wait_wbusy();
    waddr_vld = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] addr, input logic [15:0] size);
    @(negedge clk);
    raddr = addr; rsize = size; raddr_vld = 1'b1;
    wait_rbusy();
    raddr_vld = 1'b0;
  endtask

  // Entered on the negedge where wbusy is first seen; wvalid held high until
  // wbusy falls.
  task automatic wr_data(input logic [31:0] base, input int size,
                         output int hs, output int bc, output int gaps);
    int k = 0, t = 0;
    hs = 0; bc = 0; gaps = 0;
    while (wbusy && t < 4 * size + 50) begin
      bc++;
      if (rbusy) rb_during_w++;
      if (k > 0 && k < size && !wready) gaps++;
      wvalid = 1'b1; wdata = base + 32'(k);
      if (wready) begin hs++; k++; end
      @(negedge clk); t++;
    end
    wvalid = 1'b0;
    if (wbusy) tmo++;
  endtask

  task automatic rd_data(input logic [31:0] base, input logic [31:0] mask,
                         input int size, input logic [15:0] pat,
                         output int n, output int derr, output int holes,
                         output int stab, output int first, output int tail,
                         output int stalls);
    int t = 0, last_t = -1;
    logic prev_stall = 1'b0;
    logic [31:0] prev = '0;
    n = 0; derr = 0; holes = 0; stab = 0; first = -1; stalls = 0;
    while (rbusy && t < 4 * size + 50) begin
      rready = pat[t % 16];
      if (prev_stall && (!rvalid || rdata !== prev)) stab++;
      if (first >= 0 && n < size && !rvalid) holes++;
      if (rvalid) begin
        if (first < 0) first = t;
        if (rready) begin
          if ((rdata & mask) !== ((base + 32'(n)) & mask)) derr++;
          n++; last_t = t;
        end else stalls++;
      end
      prev_stall = rvalid && !rready;
      prev = rdata;
      @(negedge clk); t++;
    end
    rready = 1'b0;
    tail = t - last_t;
    if (rbusy) tmo++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if ({b_wbusy, b_wready, b_rbusy, b_rvalid, b_err, b_rdata} !== 37'd0) begin
      miscmp++; $display("FAIL reset_big got=%h exp=0", {b_wbusy, b_wready, b_rbusy, b_rvalid, b_err, b_rdata}); end
    vec++; if ({s_wbusy, s_wready, s_rbusy, s_rvalid, s_err, s_rdata} !== 37'd0) begin
      miscmp++; $display("FAIL reset_small got=%h exp=0", {s_wbusy, s_wready, s_rbusy, s_rvalid, s_err, s_rdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int hs, bc, gaps, n, derr, holes, stab, first, tail, stalls;
    sel = 1'b0;
    wr_start(32'h0, 16'd1000);
    wr_data(32'h0, 1000, hs, bc, gaps);
    vec++; if (hs !== 1000) begin miscmp++; $display("FAIL stream_wr_hs got=%0d exp=1000", hs); end
    vec++; if (bc !== 1001) begin miscmp++; $display("FAIL stream_wbusy_cycles got=%0d exp=1001", bc); end
    rd_start(32'h0, 16'd1000);
    rd_data(32'h0, 32'hFFFF_FFFF, 1000, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 1000) begin miscmp++; $display("FAIL stream_rd_beats got=%0d exp=1000", n); end
    vec++; if (derr !== 0) begin miscmp++; $display("FAIL stream_rd_data got=%0d bad exp=0", derr); end
    vec++; if (holes !== 0) begin miscmp++; $display("FAIL stream_rd_gaps got=%0d exp=0", holes); end
    vec++; if (first < 0 || first > 3) begin miscmp++; $display("FAIL stream_rd_latency got=%0d exp<=3", first); end
    vec++; if (tail > 2) begin miscmp++; $display("FAIL stream_rbusy_tail got=%0d exp<=2", tail); end
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL stream_timeout got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_multi();
    int hs, bc, gaps, n, derr, holes, stab, first, tail, stalls;
    logic [31:0] base;
    sel = 1'b0;
    for (int b = 0; b < 5; b++) begin
      base = {16'(b + 1), 16'(b * 1000)};
      wr_start(32'(b * 4000), 16'd1000);
      wr_data(base, 1000, hs, bc, gaps);
      vec++; if (hs !== 1000 || bc !== 1001) begin miscmp++;
        $display("FAIL multi_wr[%0d] got hs=%0d busy=%0d exp 1000/1001", b, hs, bc); end
      rd_start(32'(b * 4000), 16'd1000);
      rd_data(base, 32'h0000_FFFF, 1000, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
      vec++; if (n !== 1000 || derr !== 0) begin miscmp++;
        $display("FAIL multi_rd[%0d] got beats=%0d bad=%0d exp 1000/0", b, n, derr); end
    end
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL multi_timeout got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_backpressure();
    int hs, bc, gaps, n, derr, holes, stab, first, tail, stalls;
    sel = 1'b0;
    wr_start(32'h100, 16'd8);
    wr_data(32'hA0, 8, hs, bc, gaps);
    rd_start(32'h100, 16'd8);
    // rready per cycle: 1,0,0,1,0,1,1,0,0,1,0,1,...
    rd_data(32'hA0, 32'hFFFF_FFFF, 8, 16'h9A69, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 8) begin miscmp++; $display("FAIL bp_beats got=%0d exp=8", n); end
    vec++; if (derr !== 0) begin miscmp++; $display("FAIL bp_data got=%0d bad exp=0", derr); end
    vec++; if (stab !== 0) begin miscmp++; $display("FAIL bp_stall_stable got=%0d exp=0", stab); end
    vec++; if (stalls == 0) begin miscmp++; $display("FAIL bp_stall_seen got=%0d exp>0", stalls); end
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL bp_timeout got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_wrap();
    int hs, bc, gaps, n, derr, holes, stab, first, tail, stalls;
    sel = 1'b1;
    wr_start(32'd24, 16'd6);                 // word 6 of an 8-word memory
    wr_data(32'h10, 6, hs, bc, gaps);
    vec++; if (hs !== 6) begin miscmp++; $display("FAIL wrap_wr_hs got=%0d exp=6", hs); end
    vec++; if (gaps !== 1) begin miscmp++; $display("FAIL wrap_wready_gaps got=%0d exp=1", gaps); end
    vec++; if (bc !== 8) begin miscmp++; $display("FAIL wrap_wbusy_cycles got=%0d exp=8", bc); end
    rd_start(32'd0, 16'd4);                  // words 0..3 hold beats 2..5
    rd_data(32'h12, 32'hFFFF_FFFF, 4, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 4 || derr !== 0) begin miscmp++; $display("FAIL wrap_rd_low got beats=%0d bad=%0d exp 4/0", n, derr); end
    rd_start(32'd24, 16'd2);                 // words 6,7 hold beats 0,1
    rd_data(32'h10, 32'hFFFF_FFFF, 2, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 2 || derr !== 0) begin miscmp++; $display("FAIL wrap_rd_high got beats=%0d bad=%0d exp 2/0", n, derr); end
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL wrap_timeout got=%0d exp=0", tmo); tmo = 0; end
    sel = 1'b0;
  endtask

  task automatic test_tie();
    int hs, bc, gaps, n, derr, holes, stab, first, tail, stalls;
    sel = 1'b0;
    @(negedge clk);
    waddr = 32'h200; wsize = 16'd4; raddr = 32'h200; rsize = 16'd4;
    waddr_vld = 1'b1; raddr_vld = 1'b1;
    wait_wbusy();
    vec++; if (rbusy !== 1'b0) begin miscmp++; $display("FAIL tie_write_first got rbusy=%b exp=0", rbusy); end
    waddr_vld = 1'b0;
    rb_during_w = 0;
    wr_data(32'hC0, 4, hs, bc, gaps);
    vec++; if (hs !== 4 || rb_during_w !== 0) begin miscmp++;
      $display("FAIL tie_write got hs=%0d rbusy_cycles=%0d exp 4/0", hs, rb_during_w); end
    wait_rbusy();
    raddr_vld = 1'b0;
    rd_data(32'hC0, 32'hFFFF_FFFF, 4, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 4 || derr !== 0) begin miscmp++; $display("FAIL tie_read got beats=%0d bad=%0d exp 4/0", n, derr); end
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL tie_timeout got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_reset_mid();
    int k = 0, t = 0, bc = 0, wr = 0, n, derr, holes, stab, first, tail, stalls;
    sel = 1'b0;
    wr_start(32'h4000, 16'd100);
    while (k < 10 && t < 100) begin
      wvalid = 1'b1; wdata = 32'h600 + 32'(k);
      if (wready) k++;
      @(negedge clk); t++;
    end
    rst_n = 1'b0;
    #1;
    vec++; if ({b_wbusy, b_wready, b_rbusy, b_rvalid, b_err, b_rdata} !== 37'd0) begin
      miscmp++; $display("FAIL midrst_outputs got=%h exp=0", {b_wbusy, b_wready, b_rbusy, b_rvalid, b_err, b_rdata}); end
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if ({b_wbusy, b_wready, b_rbusy, b_rvalid, b_err} !== 5'd0) begin
      miscmp++; $display("FAIL midrst_hold got=%b exp=0", {b_wbusy, b_wready, b_rbusy, b_rvalid, b_err}); end
    rst_n = 1'b1;
    rd_start(32'h4000, 16'd10);
    rd_data(32'h600, 32'hFFFF_FFFF, 10, 16'hFFFF, n, derr, holes, stab, first, tail, stalls);
    vec++; if (n !== 10 || derr !== 0) begin miscmp++; $display("FAIL midrst_kept got beats=%0d bad=%0d exp 10/0", n, derr); end
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL err_clear got=%b exp=0", err); end
    @(negedge clk); wvalid = 1'b1;
    @(negedge clk); wvalid = 1'b0;
    vec++; if (err !== 1'b1) begin miscmp++; $display("FAIL err_set got=%b exp=1", err); end
    // Zero-size write with vld held past the burst end: must run only once.
    @(negedge clk); waddr = 32'h300; wsize = 16'd0; waddr_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wbusy) bc++;
      if (wready) wr++;
      if (i == 3) waddr_vld = 1'b0;
    end
    vec++; if (bc !== 2) begin miscmp++; $display("FAIL zero_wbusy_cycles got=%0d exp=2", bc); end
    vec++; if (wr !== 0) begin miscmp++; $display("FAIL zero_wready got=%0d exp=0", wr); end
    vec++; if (err !== 1'b1) begin miscmp++; $display("FAIL err_sticky got=%b exp=1", err); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL err_reset got=%b exp=0", err); end
    @(negedge clk); rst_n = 1'b1;
    vec++; if (tmo !== 0) begin miscmp++; $display("FAIL midrst_timeout got=%0d exp=0", tmo); tmo = 0; end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_multi();
    test_backpressure();
    test_wrap();
    test_tie();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
